// File: rtl/shf_pkg.sv
// Shared definitions for the shifter sequencing stage: shifter mode codes,
// FSM state encoding and the iterate-mode predicate.
package shf_pkg;

    localparam logic [3:0] SHF_SHL = 4'b0000;
    localparam logic [3:0] SHF_SHR = 4'b0001;
    localparam logic [3:0] SHF_ROL = 4'b0010;
    localparam logic [3:0] SHF_ROR = 4'b0011;
    localparam logic [3:0] SHF_SAL = 4'b0100;
    localparam logic [3:0] SHF_SAR = 4'b0101;
    localparam logic [3:0] SHF_SWP = 4'b0110;
    localparam logic [3:0] SHF_BSW = 4'b0111;
    localparam logic [3:0] SHF_RCL = 4'b1000;
    localparam logic [3:0] SHF_RCR = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic is_iter_mode(input logic [3:0] mode,
                                          input logic [3:0] sal_code,
                                          input logic [3:0] sar_code);
        return (mode == sal_code) || (mode == sar_code);
    endfunction

endpackage

// File: rtl/shf_seq.sv
// Sequencer in front of the combinational 16-bit shifter: holds operands,
// iterates single-bit arithmetic shifts, and hands the result to writeback.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a request; REQ_READY=1
//   EXEC  | one shifter pass per edge; CNT counts passes remaining
//   DONE  | result held on RES_*; leaves on RES_READY
module shf_seq
    import shf_pkg::*;
#(
    parameter int         DW       = 16,
    parameter logic [3:0] SAL_CODE = SHF_SAL,
    parameter logic [3:0] SAR_CODE = SHF_SAR
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          FLUSH,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic [DW-1:0] REQ_DATA,
    input  logic [3:0]    REQ_TIMES,
    input  logic [3:0]    REQ_MODE,
    input  logic [DW-1:0] REQ_FLAG,
    output logic [DW-1:0] SHF_IN,
    output logic [3:0]    SHF_TIMES,
    output logic [3:0]    SHF_MODE,
    output logic [DW-1:0] SHF_FLAG_in,
    input  logic [DW-1:0] SHF_OUT,
    input  logic [DW-1:0] SHF_FLAG_out,
    output logic          RES_VALID,
    input  logic          RES_READY,
    output logic [DW-1:0] RES_DATA,
    output logic [DW-1:0] RES_FLAG,
    output logic          BUSY
);

    state_t        state;
    logic [DW-1:0] acc_data;
    logic [DW-1:0] acc_flag;
    logic [3:0]    mode_q;
    logic [3:0]    times_q;
    logic [4:0]    cnt;

    logic req_iter;
    logic mode_iter;

    assign req_iter  = is_iter_mode(REQ_MODE, SAL_CODE, SAR_CODE);
    assign mode_iter = is_iter_mode(mode_q, SAL_CODE, SAR_CODE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            acc_data <= '0;
            acc_flag <= '0;
            mode_q   <= '0;
            times_q  <= '0;
            cnt      <= '0;
        end else if (FLUSH) begin
            // Abort wins over everything; accumulator contents are left as-is.
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        acc_data <= REQ_DATA;
                        acc_flag <= REQ_FLAG;
                        mode_q   <= REQ_MODE;
                        times_q  <= REQ_TIMES;
                        if (req_iter) begin
                            cnt   <= {1'b0, REQ_TIMES};
                            state <= (REQ_TIMES == 4'd0) ? ST_DONE : ST_EXEC;
                        end else begin
                            cnt   <= 5'd1;
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    acc_data <= SHF_OUT;
                    acc_flag <= SHF_FLAG_out;
                    if (cnt != 5'd0) begin
                        cnt <= cnt - 5'd1;
                    end
                    if (cnt <= 5'd1) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (RES_READY) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Iterating modes always ask the shifter for a single bit per pass.
    assign SHF_IN      = acc_data;
    assign SHF_FLAG_in = acc_flag;
    assign SHF_MODE    = mode_q;
    assign SHF_TIMES   = mode_iter ? 4'd1 : times_q;

    assign REQ_READY = (state == ST_IDLE);
    assign RES_VALID = (state == ST_DONE);
    assign BUSY      = (state != ST_IDLE);
    assign RES_DATA  = acc_data;
    assign RES_FLAG  = acc_flag;

endmodule

// File: tb/tb_shf_seq.sv
// Self-checking bench for shf_seq with a behavioural shifter attached and a
// result scoreboard filled at accept time and drained at the DONE handshake.
module tb_shf_seq;
    import shf_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        FLUSH;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [15:0] REQ_DATA;
    logic [3:0]  REQ_TIMES;
    logic [3:0]  REQ_MODE;
    logic [15:0] REQ_FLAG;
    logic [15:0] SHF_IN;
    logic [3:0]  SHF_TIMES;
    logic [3:0]  SHF_MODE;
    logic [15:0] SHF_FLAG_in;
    logic [15:0] SHF_OUT;
    logic [15:0] SHF_FLAG_out;
    logic        RES_VALID;
    logic        RES_READY;
    logic [15:0] RES_DATA;
    logic [15:0] RES_FLAG;
    logic        BUSY;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    shf_seq dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_DATA(REQ_DATA), .REQ_TIMES(REQ_TIMES), .REQ_MODE(REQ_MODE), .REQ_FLAG(REQ_FLAG),
        .SHF_IN(SHF_IN), .SHF_TIMES(SHF_TIMES), .SHF_MODE(SHF_MODE), .SHF_FLAG_in(SHF_FLAG_in),
        .SHF_OUT(SHF_OUT), .SHF_FLAG_out(SHF_FLAG_out),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA(RES_DATA), .RES_FLAG(RES_FLAG), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Behavioural shifter: returns {flag, data}. SAL/SAR put the shifted-out bit in flag[13].
    function automatic logic [31:0] shf_pass(input logic [15:0] d, input logic [15:0] f,
                                             input logic [3:0] t, input logic [3:0] m);
        logic [15:0] rd;
        logic [15:0] rf;
        rd = d;
        rf = f;
        case (m)
            4'b0000: rd = d << t;
            4'b0100: begin rd = {d[14:0], 1'b0};  rf[13] = d[15]; end
            4'b0101: begin rd = {d[15], d[15:1]}; rf[13] = d[0];  end
            default: rd = d;
        endcase
        return {rf, rd};
    endfunction

    always_comb begin
        {SHF_FLAG_out, SHF_OUT} = shf_pass(SHF_IN, SHF_FLAG_in, SHF_TIMES, SHF_MODE);
    end

    function automatic logic [31:0] expect_res(input logic [15:0] d, input logic [3:0] t,
                                               input logic [3:0] m, input logic [15:0] f);
        logic [31:0] r;
        logic        it;
        int          p;
        it = (m == 4'b0100) || (m == 4'b0101);
        p  = it ? int'(t) : 1;
        r  = {f, d};
        for (int i = 0; i < p; i++) begin
            r = shf_pass(r[15:0], r[31:16], it ? 4'd1 : t, m);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic start_op(input logic [15:0] d, input logic [3:0] t,
                            input logic [3:0] m, input logic [15:0] f, input string tag);
        @(negedge CLK);
        REQ_DATA  = d;
        REQ_TIMES = t;
        REQ_MODE  = m;
        REQ_FLAG  = f;
        REQ_VALID = 1'b1;
        chk({tag, "_req_ready"}, 32'(REQ_READY), 32'd1);
        sb.push_back(expect_res(d, t, m, f));
        @(posedge CLK);
    endtask

    // Counts edges after the accept edge until RES_VALID is seen, checking SHF_TIMES meanwhile.
    task automatic wait_valid(input logic [3:0] exp_st, input string tag, output int n);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        n = 0;
        while (!RES_VALID && n < 40) begin
            chk({tag, "_shf_times"}, 32'(SHF_TIMES), 32'(exp_st));
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic check_result(input string tag);
        logic [31:0] e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, 32'(RES_DATA), 32'(e[15:0]));
            chk({tag, "_flag"}, 32'(RES_FLAG), 32'(e[31:16]));
        end
    endtask

    task automatic finish_op(input int p, input logic [3:0] exp_st, input string tag);
        int n;
        wait_valid(exp_st, tag, n);
        chk({tag, "_latency"}, 32'(n), 32'(p));
        check_result(tag);
        RES_READY = 1'b1;
        @(negedge CLK);
        RES_READY = 1'b0;
        chk({tag, "_idle_ready"}, 32'(REQ_READY), 32'd1);
        chk({tag, "_idle_valid"}, 32'(RES_VALID), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_shf_in"},   32'(SHF_IN), 32'd0);
        chk({tag, "_shf_times"}, 32'(SHF_TIMES), 32'd0);
        chk({tag, "_shf_mode"}, 32'(SHF_MODE), 32'd0);
        chk({tag, "_shf_flag"}, 32'(SHF_FLAG_in), 32'd0);
        chk({tag, "_res"},      {RES_FLAG, RES_DATA}, 32'd0);
        chk({tag, "_res_valid"}, 32'(RES_VALID), 32'd0);
        chk({tag, "_busy"},     32'(BUSY), 32'd0);
        chk({tag, "_req_ready"}, 32'(REQ_READY), 32'd1);
    endtask

    initial begin
        int n;
        logic seen;
        RST_N = 1'b0; FLUSH = 1'b0; REQ_VALID = 1'b0; RES_READY = 1'b0;
        REQ_DATA = '0; REQ_TIMES = '0; REQ_MODE = '0; REQ_FLAG = '0;
        #12;
        check_reset_outputs("rst");
        @(negedge CLK);
        RST_N = 1'b1;

        // SHL by 4: one pass with the full count
        start_op(16'h0001, 4'd4, 4'b0000, 16'h0000, "shl");
        finish_op(1, 4'd4, "shl");

        // SAL by 3: three single-bit passes
        start_op(16'h0001, 4'd3, 4'b0100, 16'h0000, "sal");
        finish_op(3, 4'd1, "sal");

        // SAR with zero count: no passes, operands untouched
        start_op(16'hBEEF, 4'd0, 4'b0101, 16'h1234, "sar0");
        finish_op(0, 4'd1, "sar0");

        // SAR chaining flag bit 13 across passes
        start_op(16'h8003, 4'd2, 4'b0101, 16'h0000, "sar2");
        finish_op(2, 4'd1, "sar2");

        // Undefined mode passes through in one pass
        start_op(16'h1357, 4'd7, 4'b1100, 16'h00FF, "mode_c");
        finish_op(1, 4'd7, "mode_c");

        // Backpressure with a second request pending
        start_op(16'h00F0, 4'd2, 4'b0000, 16'hA5A5, "bp1");
        wait_valid(4'd2, "bp1", n);
        chk("bp1_latency", 32'(n), 32'd1);
        REQ_DATA = 16'h0101; REQ_TIMES = 4'd1; REQ_MODE = 4'b0100; REQ_FLAG = 16'h0000;
        REQ_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_req_ready", 32'(REQ_READY), 32'd0);
            chk("bp_res_valid", 32'(RES_VALID), 32'd1);
            chk("bp_hold", {RES_FLAG, RES_DATA}, 32'hA5A5_03C0);
        end
        check_result("bp1");
        RES_READY = 1'b1;
        @(negedge CLK);
        RES_READY = 1'b0;
        chk("bp_idle_ready", 32'(REQ_READY), 32'd1);
        chk("bp_idle_busy", 32'(BUSY), 32'd0);
        sb.push_back(expect_res(16'h0101, 4'd1, 4'b0100, 16'h0000));
        @(posedge CLK);
        finish_op(1, 4'd1, "bp2");

        // FLUSH during a 15-pass SAL, asserted so pass 7 is aborted
        start_op(16'h0001, 4'd15, 4'b0100, 16'h0000, "fl");
        @(negedge CLK);
        REQ_VALID = 1'b0;
        repeat (6) @(negedge CLK);
        chk("fl_acc_pass6", 32'(SHF_IN), 32'h0040);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        chk("fl_req_ready", 32'(REQ_READY), 32'd1);
        chk("fl_busy", 32'(BUSY), 32'd0);
        seen = RES_VALID;
        repeat (5) begin
            @(negedge CLK);
            seen = seen | RES_VALID;
        end
        chk("fl_no_valid", 32'(seen), 32'd0);
        sb.delete();

        // Asynchronous reset mid-EXEC, between edges
        start_op(16'h0003, 4'd10, 4'b0100, 16'h0F0F, "ar");
        @(negedge CLK);
        REQ_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1 check_reset_outputs("ar");
        sb.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        start_op(16'h4001, 4'd2, 4'b0100, 16'h0000, "post");
        finish_op(2, 4'd1, "post");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
